// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill engine streaming pipelined memory returns into the data array.
// Optional critical-word-first ordering: CACHE_FILL_CRITICAL_FIRST_EN.
module cache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   output logic              fsm_busy,
   output logic              mem_enable,
   output logic [ADDR_W-1:0] memory_address,
   input  logic              memory_data_valid,
   input  logic [DATA_W-1:0] memory_data,
   output logic              write_data_array,
   output logic [ADDR_W-1:0] cache_word_addr,
   output logic [DATA_W-1:0] cache_word_data,
   output logic              write_tag_array,
   output logic              fill_done
);

   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W = OFF_W + 1;
   localparam int BLK_W = ADDR_W - OFF_W - 1;
   localparam logic [CNT_W-1:0] BW_C     = CNT_W'(BLOCK_WORDS);
   localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_WORDS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t           state_q, state_d;
   logic [BLK_W-1:0] base_q, base_d;
   logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
   logic [OFF_W-1:0] iss_k, rcv_k, iss_off, rcv_off;
   logic             accept;
   logic             unused_addr_bits;

   // Once every request is out, the request address parks on the last word issued.
   assign iss_k = (issue_cnt_q == BW_C) ? LAST_OFF : issue_cnt_q[OFF_W-1:0];
   assign rcv_k = recv_cnt_q[OFF_W-1:0];
   assign unused_addr_bits = ^miss_address[OFF_W:0];

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
   logic [OFF_W-1:0] start_q, start_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) start_q <= '0;
      else        start_q <= start_d;
   end

   always_comb begin
      start_d = start_q;
      if (state_q == IDLE && miss_detected) start_d = miss_address[OFF_W:1];
   end

   // Offsets wrap inside the block because the sum is truncated to OFF_W bits.
   assign iss_off = iss_k + start_q;
   assign rcv_off = rcv_k + start_q;
`else
   assign iss_off = iss_k;
   assign rcv_off = rcv_k;
`endif

   assign accept = memory_data_valid && (recv_cnt_q < issue_cnt_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      issue_cnt_d      = issue_cnt_q;
      recv_cnt_d       = recv_cnt_q;
      fsm_busy         = 1'b0;
      mem_enable       = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      cache_word_addr  = '0;
      cache_word_data  = '0;
      write_tag_array  = 1'b0;
      fill_done        = 1'b0;
      case (state_q)
         IDLE: begin
            // Stall combinationally so the core freezes in the miss cycle itself.
            fsm_busy = miss_detected & rst_n;
            if (miss_detected) begin
               base_d      = miss_address[ADDR_W-1:OFF_W+1];
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
               state_d     = FILL;
            end
         end
         FILL: begin
            fsm_busy       = 1'b1;
            memory_address = {base_q, iss_off, 1'b0};
            if (issue_cnt_q < BW_C) begin
               mem_enable  = 1'b1;
               issue_cnt_d = issue_cnt_q + 1'b1;
            end
            if (accept) begin
               write_data_array = 1'b1;
               cache_word_addr  = {base_q, rcv_off, 1'b0};
               cache_word_data  = memory_data;
               recv_cnt_d       = recv_cnt_q + 1'b1;
               if (recv_cnt_q == BW_C - 1'b1) begin
                  write_tag_array = 1'b1;
                  fill_done       = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed self-checking bench for cache_fill_fsm with a fixed-latency memory.
module tb_cache_fill_fsm;

   logic        clk;
   logic        rst_n;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        fsm_busy;
   logic        mem_enable;
   logic [15:0] memory_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        write_data_array;
   logic [15:0] cache_word_addr;
   logic [15:0] cache_word_data;
   logic        write_tag_array;
   logic        fill_done;

   int total = 0;
   int bad   = 0;

   cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .fsm_busy          (fsm_busy),
      .mem_enable        (mem_enable),
      .memory_address    (memory_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .write_data_array  (write_data_array),
      .cache_word_addr   (cache_word_addr),
      .cache_word_data   (cache_word_data),
      .write_tag_array   (write_tag_array),
      .fill_done         (fill_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      rst_n             = 1'b0;
      miss_detected     = 1'b1;
      miss_address      = 16'h1236;
      memory_data_valid = 1'b1;
      memory_data       = 16'hFFFF;
      @(negedge clk);
      total++;
      if ({fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done,
           memory_address, cache_word_addr, cache_word_data} !== 53'd0) begin
         bad++;
         $display("FAIL reset_during outputs=%h expected 0", {fsm_busy, mem_enable, write_data_array,
                  write_tag_array, fill_done, memory_address, cache_word_addr, cache_word_data});
      end
      @(posedge clk); #1;
      rst_n             = 1'b1;
      miss_detected     = 1'b0;
      memory_data_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done,
           memory_address, cache_word_addr, cache_word_data} !== 53'd0) begin
         bad++;
         $display("FAIL reset_after outputs=%h expected 0", {fsm_busy, mem_enable, write_data_array,
                  write_tag_array, fill_done, memory_address, cache_word_addr, cache_word_data});
      end
   endtask

   task automatic test_idle_noise();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         miss_detected     = 1'b0;
         miss_address      = 16'(16'h2000 + i * 2);
         memory_data_valid = 1'b1;
         memory_data       = 16'(16'h0300 + i);
         @(negedge clk);
         total++;
         if ({fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done,
              memory_address, cache_word_addr, cache_word_data} !== 53'd0) begin
            bad++;
            $display("FAIL idle_noise i=%0d outputs=%h expected 0", i, {fsm_busy, mem_enable,
                     write_data_array, write_tag_array, fill_done, memory_address, cache_word_addr,
                     cache_word_data});
         end
      end
      memory_data_valid = 1'b0;
   endtask

   // One complete fill against a memory of latency lat; optional early/late spurious valids and a miss in cycle 3.
   task automatic test_fill(input logic [15:0] maddr, input int lat, input bit early, input bit late,
                            input bit miss_mid);
      logic [15:0] base, exp_addr, last_req;
      logic [2:0]  start, off;
      logic        exp_busy, exp_req, exp_wr, exp_tag;
      int          k, nwr;
      base  = maddr & 16'hFFF0;
      start = 3'd0;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
      start = maddr[3:1];
`endif
      off      = start + 3'd7;
      last_req = base + {12'd0, off, 1'b0};
      nwr      = 0;
      @(posedge clk); #1;
      miss_detected     = 1'b1;
      miss_address      = maddr;
      memory_data_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({fsm_busy, mem_enable, write_data_array} !== 3'b100) begin
         bad++;
         $display("FAIL fill_c0 addr=%h busy/men/wr=%b%b%b expected 100", maddr, fsm_busy, mem_enable,
                  write_data_array);
      end
      for (int c = 1; c <= 9 + lat; c++) begin
         @(posedge clk); #1;
         miss_detected     = miss_mid && (c == 3);
         miss_address      = (miss_mid && (c == 3)) ? 16'h4000 : maddr;
         k                 = c - 1 - lat;
         memory_data_valid = (k >= 0 && k < 8) || (early && c == 1) || (late && c == 9 + lat);
         memory_data       = (k >= 0 && k < 8) ? 16'(16'h5A00 + k) : 16'hDEAD;
         @(negedge clk);
         exp_busy = (c <= 8 + lat);
         exp_req  = (c <= 8);
         exp_wr   = (k >= 0 && k < 8);
         exp_tag  = (k == 7);
         total++;
         if (fsm_busy !== exp_busy) begin
            bad++;
            $display("FAIL busy addr=%h c=%0d got=%b exp=%b", maddr, c, fsm_busy, exp_busy);
         end
         total++;
         if (mem_enable !== exp_req) begin
            bad++;
            $display("FAIL mem_enable addr=%h c=%0d got=%b exp=%b", maddr, c, mem_enable, exp_req);
         end
         if (exp_req) begin
            off      = start + 3'(c - 1);
            exp_addr = base + {12'd0, off, 1'b0};
            total++;
            if (memory_address !== exp_addr) begin
               bad++;
               $display("FAIL req_addr c=%0d got=%h exp=%h", c, memory_address, exp_addr);
            end
         end else if (exp_busy) begin
            total++;
            if (memory_address !== last_req) begin
               bad++;
               $display("FAIL req_hold c=%0d got=%h exp=%h", c, memory_address, last_req);
            end
         end
         total++;
         if (write_data_array !== exp_wr) begin
            bad++;
            $display("FAIL write c=%0d got=%b exp=%b", c, write_data_array, exp_wr);
         end
         if (exp_wr) begin
            off      = start + 3'(k);
            exp_addr = base + {12'd0, off, 1'b0};
            total++;
            if (cache_word_addr !== exp_addr || cache_word_data !== 16'(16'h5A00 + k)) begin
               bad++;
               $display("FAIL word c=%0d got=%h/%h exp=%h/%h", c, cache_word_addr, cache_word_data,
                        exp_addr, 16'(16'h5A00 + k));
            end
         end
         total++;
         if ({write_tag_array, fill_done} !== {exp_tag, exp_tag}) begin
            bad++;
            $display("FAIL tag_done c=%0d got=%b%b exp=%b%b", c, write_tag_array, fill_done, exp_tag,
                     exp_tag);
         end
         if (write_data_array === 1'b1) nwr++;
      end
      memory_data_valid = 1'b0;
      miss_detected     = 1'b0;
      total++;
      if (nwr !== 8) begin
         bad++;
         $display("FAIL write_count addr=%h got=%0d exp=8", maddr, nwr);
      end
   endtask

   task automatic test_reset_mid_fill();
      int k;
      @(posedge clk); #1;
      miss_detected     = 1'b1;
      miss_address      = 16'h1230;
      memory_data_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         miss_detected     = 1'b0;
         k                 = c - 5;
         memory_data_valid = (k >= 0 && k < 8);
         memory_data       = 16'(16'h7700 + k);
         if (c == 8) rst_n = 1'b0;
         if (c == 9) rst_n = 1'b1;
         @(negedge clk);
         if (c >= 8) begin
            total++;
            if ({fsm_busy, mem_enable, write_data_array, write_tag_array, fill_done,
                 memory_address, cache_word_addr, cache_word_data} !== 53'd0) begin
               bad++;
               $display("FAIL reset_mid c=%0d outputs=%h expected 0", c, {fsm_busy, mem_enable,
                        write_data_array, write_tag_array, fill_done, memory_address,
                        cache_word_addr, cache_word_data});
            end
         end else if (c >= 5) begin
            total++;
            if (write_data_array !== 1'b1) begin
               bad++;
               $display("FAIL reset_mid_pre c=%0d write=%b exp=1", c, write_data_array);
            end
         end
      end
      memory_data_valid = 1'b0;
      test_fill(16'hFFF2, 4, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_critical_first();
      test_fill(16'h123A, 4, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_idle_noise();
      test_fill(16'h1236, 4, 1'b1, 1'b1, 1'b0);
      test_fill(16'h1230, 4, 1'b0, 1'b0, 1'b1);
      test_fill(16'h0002, 1, 1'b0, 1'b1, 1'b0);
      test_reset_mid_fill();
      test_critical_first();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
